// File: rtl/mips_prog_loader_if.sv
`default_nettype none
// ============================================================================
// mips_prog_loader_if : byte-stream input and instruction-memory write bus
// Revision: 1.0
// ============================================================================
interface mips_prog_loader_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMEM_ADDR_WIDTH = 8
);
    logic [7:0]                 rx_data;
    logic                       rx_valid;
    logic                       rx_ready;
    logic                       imem_we;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0]      imem_wdata;

    modport slave  (input  rx_data, rx_valid,
                    output rx_ready, imem_we, imem_addr, imem_wdata);
    modport master (output rx_data, rx_valid,
                    input  rx_ready, imem_we, imem_addr, imem_wdata);
endinterface
`default_nettype wire

// File: rtl/mips_prog_loader.sv
`default_nettype none
// ============================================================================
// mips_prog_loader : assembles MSB-first program bytes into words, writes them
// to instruction memory, then runs the CPU until it halts.
// Revision: 1.0
// ============================================================================
module mips_prog_loader #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    IMEM_ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD       = 32'hFFFF_FFFF
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    mips_prog_loader_if.slave             bus,
    input  wire logic                     i_cpu_halt,
    output logic                          o_cpu_reset,
    output logic [IMEM_ADDR_WIDTH:0]      o_word_count,
    output logic                          o_done,
    output logic                          o_error
);
    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_WRITE = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [IMEM_ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

    state_t                     r_state;
    state_t                     w_next;
    logic [1:0]                 r_byte_cnt;
    logic [DATA_WIDTH-9:0]      r_shift;
    logic [IMEM_ADDR_WIDTH-1:0] r_ptr;
    logic [IMEM_ADDR_WIDTH:0]   r_word_count;
    logic                       r_rx_ready;
    logic                       r_imem_we;
    logic [IMEM_ADDR_WIDTH-1:0] r_imem_addr;
    logic [DATA_WIDTH-1:0]      r_imem_wdata;
    logic                       r_cpu_reset;
    logic                       r_done;
    logic                       r_error;
    logic                       w_accept;
    logic [DATA_WIDTH-1:0]      w_word;

    assign w_accept = bus.rx_valid && r_rx_ready;
    assign w_word   = {r_shift, bus.rx_data};

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (w_accept && r_byte_cnt == 2'd3) w_next = S_WRITE;
            S_WRITE: begin
                if (r_imem_wdata == HALT_WORD)  w_next = S_RUN;
                else if (r_ptr == c_LAST_ADDR)  w_next = S_ERROR;
                else                            w_next = S_LOAD;
            end
            S_RUN:   if (i_cpu_halt) w_next = S_DONE;
            S_DONE:  w_next = S_DONE;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_LOAD;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_byte_cnt   <= '0;
            r_shift      <= '0;
            r_ptr        <= '0;
            r_word_count <= '0;
            r_rx_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_reset  <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_rx_ready  <= (w_next == S_LOAD);
            r_imem_we   <= (w_next == S_WRITE);
            r_cpu_reset <= !((w_next == S_RUN) || (w_next == S_DONE));
            r_done      <= (w_next == S_DONE);
            r_error     <= (w_next == S_ERROR);
            if (w_accept) begin
                r_shift    <= w_word[DATA_WIDTH-9:0];
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_byte_cnt == 2'd3) begin
                    r_imem_wdata <= w_word;
                    r_imem_addr  <= r_ptr;
                end
            end
            if (r_state == S_WRITE) begin
                r_word_count <= r_word_count + 1'b1;
                if (w_next == S_LOAD) r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    assign bus.rx_ready   = r_rx_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign o_cpu_reset    = r_cpu_reset;
    assign o_word_count   = r_word_count;
    assign o_done         = r_done;
    assign o_error        = r_error;
endmodule
`default_nettype wire

// File: tb/tb_mips_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_mips_prog_loader : table, directed and random checks of the loader
// Revision: 1.0
// ============================================================================
module tb_mips_prog_loader;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       halt_a, halt_b;
    logic       cpu_reset_a, cpu_reset_b, done_a, done_b, err_a, err_b;
    logic [8:0] count_a;
    logic [2:0] count_b;

    mips_prog_loader_if #(.DATA_WIDTH(32), .IMEM_ADDR_WIDTH(8)) ifa ();
    mips_prog_loader_if #(.DATA_WIDTH(32), .IMEM_ADDR_WIDTH(2)) ifb ();

    mips_prog_loader #(.DATA_WIDTH(32), .IMEM_ADDR_WIDTH(8), .HALT_WORD(HALT)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave), .i_cpu_halt(halt_a),
        .o_cpu_reset(cpu_reset_a), .o_word_count(count_a), .o_done(done_a), .o_error(err_a));
    mips_prog_loader #(.DATA_WIDTH(32), .IMEM_ADDR_WIDTH(2), .HALT_WORD(HALT)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave), .i_cpu_halt(halt_b),
        .o_cpu_reset(cpu_reset_b), .o_word_count(count_b), .o_done(done_b), .o_error(err_b));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observed writes as {addr, data}
    logic [39:0] qa[$];
    logic [39:0] qb[$];
    always @(negedge clk) begin
        if (ifa.imem_we) begin
            qa.push_back({ifa.imem_addr, ifa.imem_wdata});
            chk("ready_during_write_a", ifa.rx_ready, 0);
        end
        if (ifb.imem_we) begin
            qb.push_back({6'd0, ifb.imem_addr, ifb.imem_wdata});
            chk("ready_during_write_b", ifb.rx_ready, 0);
        end
    end

    // Reference model: words go to consecutive addresses until HALT or memory full
    logic [31:0] prog[$];
    logic [39:0] exp_q[$];
    int          m_cnt, m_used;
    bit          m_err, m_run;

    task automatic model(input int sel);
        int depth;
        depth = (sel != 0) ? 4 : 256;
        exp_q.delete();
        m_cnt = 0; m_used = 0; m_err = 0; m_run = 0;
        foreach (prog[i]) begin
            exp_q.push_back({i[7:0], prog[i]});
            m_cnt++;
            m_used++;
            if (prog[i] == HALT) begin m_run = 1; break; end
            if (m_cnt == depth) begin m_err = 1; break; end
        end
    endtask

    task automatic set_rx(input int sel, input logic v, input logic [7:0] d);
        if (sel != 0) begin ifb.rx_valid = v; ifb.rx_data = d; end
        else          begin ifa.rx_valid = v; ifa.rx_data = d; end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel != 0) ? ifb.rx_ready : ifa.rx_ready;
    endfunction

    // Called and returns at a falling edge; on return the byte has been taken.
    task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
        int g, n;
        if (gap > 0) begin
            g = $urandom_range(gap, 0);
            repeat (g) begin set_rx(sel, 1'b0, 8'h00); @(negedge clk); end
        end
        set_rx(sel, 1'b1, b);
        n = 0;
        while (get_ready(sel) !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("byte_accept_timeout", 0, 1);
        else @(negedge clk);
    endtask

    task automatic send_prog(input int sel, input int gap);
        for (int i = 0; i < m_used; i++)
            for (int k = 3; k >= 0; k--) send_byte(sel, prog[i][8*k +: 8], gap);
        set_rx(sel, 1'b0, 8'h00);
    endtask

    task automatic do_reset(input bit check);
        reset = 1'b0;
        set_rx(0, 1'b0, 8'h00);
        set_rx(1, 1'b0, 8'h00);
        @(negedge clk);
        qa.delete();
        qb.delete();
        if (check) begin
            chk("rst_rx_ready", ifa.rx_ready, 0);
            chk("rst_imem_we", ifa.imem_we, 0);
            chk("rst_imem_addr", ifa.imem_addr, 0);
            chk("rst_imem_wdata", ifa.imem_wdata, 0);
            chk("rst_cpu_reset", cpu_reset_a, 1);
            chk("rst_word_count", count_a, 0);
            chk("rst_done", done_a, 0);
            chk("rst_error", err_a, 0);
        end
        reset = 1'b1;
    endtask

    task automatic finish_check(input int sel);
        logic [39:0] act[$];
        repeat (4) @(negedge clk);
        act = (sel != 0) ? qb : qa;
        chk("num_writes", act.size(), exp_q.size());
        for (int i = 0; i < act.size() && i < exp_q.size(); i++)
            chk("write_addr_data", act[i], exp_q[i]);
        chk("word_count", (sel != 0) ? 9'(count_b) : count_a, m_cnt);
        chk("error_flag", (sel != 0) ? err_b : err_a, m_err);
        chk("cpu_reset", (sel != 0) ? cpu_reset_b : cpu_reset_a, !m_run);
        chk("done_flag", (sel != 0) ? done_b : done_a, 0);
    endtask

    typedef struct {
        int             sel;
        int             n;
        logic [3:0][31:0] w;
        int             gap;
        int             exp_cnt;
        bit             exp_err;
    } vec_t;

    function automatic vec_t mk(input int sel, input int n, input logic [31:0] w0,
                                input logic [31:0] w1, input logic [31:0] w2,
                                input logic [31:0] w3, input int gap, input int cnt,
                                input bit err);
        vec_t v;
        v.sel = sel; v.n = n; v.w = {w3, w2, w1, w0};
        v.gap = gap; v.exp_cnt = cnt; v.exp_err = err;
        return v;
    endfunction

    vec_t tbl[5];

    initial begin
        tbl[0] = mk(0, 2, 32'h2001_0005, HALT, 0, 0, 0, 2, 0);
        tbl[1] = mk(0, 2, 32'h2001_0005, HALT, 0, 0, 3, 2, 0);
        tbl[2] = mk(1, 4, 32'h1, 32'h2, 32'h3, 32'h4, 0, 4, 1);
        tbl[3] = mk(1, 3, 32'h0, HALT, 32'h1234_5678, 0, 2, 2, 0);
        tbl[4] = mk(1, 4, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'hFFFF_FF00, 32'h00FF_FFFF, 1, 4, 1);

        reset = 1'b0; halt_a = 1'b0; halt_b = 1'b0;
        set_rx(0, 1'b0, 8'h00);
        set_rx(1, 1'b0, 8'h00);
        repeat (2) @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            do_reset(t == 0);
            prog.delete();
            for (int i = 0; i < tbl[t].n; i++) prog.push_back(tbl[t].w[i]);
            model(tbl[t].sel);
            chk("table_model_count", m_cnt, tbl[t].exp_cnt);
            send_prog(tbl[t].sel, tbl[t].gap);
            finish_check(tbl[t].sel);
            chk("table_error", (tbl[t].sel != 0) ? err_b : err_a, tbl[t].exp_err);
            if (tbl[t].exp_err) begin
                halt_b = 1'b1; @(negedge clk); halt_b = 1'b0; @(negedge clk);
                chk("halt_in_error_done", done_b, 0);
                chk("halt_in_error_err", err_b, 1);
                chk("halt_in_error_cpu_reset", cpu_reset_b, 1);
            end
        end

        // Directed: HALT write timing, then CPU halt and sticky DONE
        do_reset(0);
        prog.delete(); prog.push_back(32'h2001_0005); prog.push_back(HALT);
        model(0);
        for (int k = 3; k >= 0; k--) send_byte(0, prog[0][8*k +: 8], 0);
        for (int k = 3; k >= 0; k--) send_byte(0, prog[1][8*k +: 8], 0);
        set_rx(0, 1'b0, 8'h00);
        chk("halt_write_we", ifa.imem_we, 1);
        chk("halt_write_addr", ifa.imem_addr, 1);
        chk("halt_write_data", ifa.imem_wdata, HALT);
        chk("halt_write_ready", ifa.rx_ready, 0);
        chk("halt_write_cpu_reset", cpu_reset_a, 1);
        @(negedge clk);
        chk("run_cpu_reset", cpu_reset_a, 0);
        chk("run_we", ifa.imem_we, 0);
        chk("run_word_count", count_a, 2);
        halt_a = 1'b1; @(negedge clk); halt_a = 1'b0;
        chk("done_after_halt", done_a, 1);
        chk("done_cpu_reset", cpu_reset_a, 0);
        set_rx(0, 1'b1, 8'h55);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("done_ready", ifa.rx_ready, 0);
        end
        set_rx(0, 1'b0, 8'h00);
        chk("done_sticky", done_a, 1);
        chk("done_writes", qa.size(), 2);
        chk("done_word_count", count_a, 2);

        // Directed: reset mid-word discards the partial bytes
        do_reset(0);
        send_byte(0, 8'hAA, 0);
        send_byte(0, 8'hBB, 0);
        do_reset(0);
        prog.delete(); prog.push_back(32'h1122_3344); prog.push_back(HALT);
        model(0);
        send_prog(0, 0);
        finish_check(0);

        // Directed: CPU halt held high during LOAD only takes effect in RUN
        halt_a = 1'b1;
        do_reset(0);
        prog.delete(); prog.push_back(32'hCAFE_F00D); prog.push_back(HALT);
        model(0);
        send_prog(0, 0);
        chk("halt_load_we", ifa.imem_we, 1);
        chk("halt_load_done_write", done_a, 0);
        @(negedge clk);
        chk("halt_load_done_run", done_a, 0);
        chk("halt_load_cpu_reset_run", cpu_reset_a, 0);
        @(negedge clk);
        chk("halt_load_done", done_a, 1);
        halt_a = 1'b0;
        chk("halt_load_writes", qa.size(), 2);

        // Random programs with random valid gaps
        for (int r = 0; r < 8; r++) begin
            int sel, n;
            sel = $urandom_range(1, 0);
            n = $urandom_range(5, 1);
            do_reset(0);
            prog.delete();
            for (int i = 0; i < n; i++)
                prog.push_back(($urandom_range(3, 0) == 0) ? HALT : 32'($urandom));
            model(sel);
            send_prog(sel, $urandom_range(3, 0));
            finish_check(sel);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
